// File: rtl/dozator_if.sv
// -----------------------------------------------------------------------------
// dozator_if
// Selection/message bus between the menu controller and the dispense
// sequencer, plus the sequencer's valve, change and status outputs.
//
// Signals:
//   msg            controller state code (0 Idle ... 8 Activ, 9 Lapte, 10 Zahar)
//   cafea, cioco   drink selection levels
//   lapte, zahar   extra milk / extra sugar selection levels
//   fond           inserted funds, unsigned
//   valva_*        valve drive outputs (at most one high at a time)
//   rest           change amount, only non-zero while rest_valid is high
//   rest_valid     one-cycle change strobe
//   ocupat         dispense sequence in progress
//   gata           one-cycle completion pulse
//   eroare         one-cycle pulse when Activ arrives with no drink selected
//
// Modports:
//   master  controller side (drives selection/message, observes status)
//   slave   sequencer side (dozator)
// -----------------------------------------------------------------------------
interface dozator_if;
    logic [3:0] msg;
    logic       cafea;
    logic       cioco;
    logic       lapte;
    logic       zahar;
    logic [4:0] fond;

    logic       valva_cafea;
    logic       valva_cioco;
    logic       valva_lapte;
    logic       valva_zahar;
    logic [4:0] rest;
    logic       rest_valid;
    logic       ocupat;
    logic       gata;
    logic       eroare;

    modport master (
        output msg, cafea, cioco, lapte, zahar, fond,
        input  valva_cafea, valva_cioco, valva_lapte, valva_zahar,
        input  rest, rest_valid, ocupat, gata, eroare
    );

    modport slave (
        input  msg, cafea, cioco, lapte, zahar, fond,
        output valva_cafea, valva_cioco, valva_lapte, valva_zahar,
        output rest, rest_valid, ocupat, gata, eroare
    );
endinterface

// File: rtl/dozator.sv
// -----------------------------------------------------------------------------
// dozator
// Dispense sequencer for the coffee machine. Collects the order flags while
// idle, starts on the controller's Activ message, then opens the base-drink,
// milk and sugar valves back to back for their configured times, presents
// the change for one cycle and pulses completion.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset; every output drops to 0 at once
//   bus   dozator_if.slave: msg/selection/fond in, valves/rest/status out
//
// Parameters:
//   T_BAZA, T_LAPTE, T_ZAHAR  valve open times in clk cycles (1..255)
//   PRET                      drink price; change = fond - PRET, floored at 0
// -----------------------------------------------------------------------------
module dozator #(
    parameter int T_BAZA  = 8,
    parameter int T_LAPTE = 4,
    parameter int T_ZAHAR = 2,
    parameter int PRET    = 5
) (
    input  logic      clk,
    input  logic      rst,
    dozator_if.slave  bus
);

    typedef enum logic [2:0] {
        ASTEPT,
        BAZA,
        LAPTE,
        ZAHAR,
        REST,
        GATA
    } state_t;

    localparam logic [3:0] MSG_IDLE     = 4'd0;
    localparam logic [3:0] MSG_ACTIV    = 4'd8;
    localparam logic [7:0] T_BAZA_LOAD  = 8'(T_BAZA - 1);
    localparam logic [7:0] T_LAPTE_LOAD = 8'(T_LAPTE - 1);
    localparam logic [7:0] T_ZAHAR_LOAD = 8'(T_ZAHAR - 1);
    localparam logic [4:0] PRET_W       = 5'(PRET);

    state_t     state_q,      state_d;
    logic [7:0] cnt_q,        cnt_d;
    logic       sel_cafea_q,  sel_cafea_d;
    logic       sel_cioco_q,  sel_cioco_d;
    logic       sel_lapte_q,  sel_lapte_d;
    logic       sel_zahar_q,  sel_zahar_d;
    logic       armed_q,      armed_d;
    logic [4:0] rest_reg_q,   rest_reg_d;

    logic       valva_cafea_q, valva_cafea_d;
    logic       valva_cioco_q, valva_cioco_d;
    logic       valva_lapte_q, valva_lapte_d;
    logic       valva_zahar_q, valva_zahar_d;
    logic [4:0] rest_q,        rest_d;
    logic       rest_valid_q,  rest_valid_d;
    logic       ocupat_q,      ocupat_d;
    logic       gata_q,        gata_d;
    logic       eroare_q,      eroare_d;

    // Next-state logic. The order register only listens while idle, and the
    // start decision looks at the order including the flags sampled on the
    // start edge itself, so a drink chosen on the same cycle as Activ counts.
    // armed re-arms on any cycle where msg is not Activ, which limits us to
    // one sequence per entry into Activ even if msg sits at 8 afterwards.
    // Outputs are decoded from the next state so they come straight out of
    // flops and line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_cafea_d = sel_cafea_q;
        sel_cioco_d = sel_cioco_q;
        sel_lapte_d = sel_lapte_q;
        sel_zahar_d = sel_zahar_q;
        armed_d     = (bus.msg != MSG_ACTIV) ? 1'b1 : armed_q;
        rest_reg_d  = rest_reg_q;
        eroare_d    = 1'b0;

        case (state_q)
            ASTEPT: begin
                if (bus.msg == MSG_IDLE) begin
                    sel_cafea_d = 1'b0;
                    sel_cioco_d = 1'b0;
                    sel_lapte_d = 1'b0;
                    sel_zahar_d = 1'b0;
                end else begin
                    sel_cafea_d = sel_cafea_q | bus.cafea;
                    sel_cioco_d = sel_cioco_q | bus.cioco;
                    sel_lapte_d = sel_lapte_q | bus.lapte;
                    sel_zahar_d = sel_zahar_q | bus.zahar;
                end

                if ((bus.msg == MSG_ACTIV) && armed_q) begin
                    armed_d = 1'b0;
                    if (!sel_cafea_d && !sel_cioco_d) begin
                        eroare_d = 1'b1;
                    end else begin
                        state_d    = BAZA;
                        cnt_d      = T_BAZA_LOAD;
                        // Clamp rather than wrap if funds are short.
                        rest_reg_d = (bus.fond >= PRET_W) ? (bus.fond - PRET_W) : 5'd0;
                    end
                end
            end

            BAZA: begin
                if (cnt_q == 8'd0) begin
                    if (sel_lapte_q) begin
                        state_d = LAPTE;
                        cnt_d   = T_LAPTE_LOAD;
                    end else if (sel_zahar_q) begin
                        state_d = ZAHAR;
                        cnt_d   = T_ZAHAR_LOAD;
                    end else begin
                        state_d = REST;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            LAPTE: begin
                if (cnt_q == 8'd0) begin
                    if (sel_zahar_q) begin
                        state_d = ZAHAR;
                        cnt_d   = T_ZAHAR_LOAD;
                    end else begin
                        state_d = REST;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ZAHAR: begin
                if (cnt_q == 8'd0) begin
                    state_d = REST;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            REST: begin
                state_d = GATA;
            end

            GATA: begin
                state_d     = ASTEPT;
                sel_cafea_d = 1'b0;
                sel_cioco_d = 1'b0;
                sel_lapte_d = 1'b0;
                sel_zahar_d = 1'b0;
            end

            default: begin
                state_d = ASTEPT;
            end
        endcase

        // Coffee has priority when both drinks were ordered.
        valva_cafea_d = (state_d == BAZA) && sel_cafea_d;
        valva_cioco_d = (state_d == BAZA) && !sel_cafea_d && sel_cioco_d;
        valva_lapte_d = (state_d == LAPTE);
        valva_zahar_d = (state_d == ZAHAR);
        rest_valid_d  = (state_d == REST);
        rest_d        = rest_valid_d ? rest_reg_d : 5'd0;
        ocupat_d      = (state_d != ASTEPT);
        gata_d        = (state_d == GATA);
    end

    // State, order and output registers. Everything clears asynchronously so
    // an open valve shuts the moment reset is raised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ASTEPT;
            cnt_q         <= 8'd0;
            sel_cafea_q   <= 1'b0;
            sel_cioco_q   <= 1'b0;
            sel_lapte_q   <= 1'b0;
            sel_zahar_q   <= 1'b0;
            armed_q       <= 1'b0;
            rest_reg_q    <= 5'd0;
            valva_cafea_q <= 1'b0;
            valva_cioco_q <= 1'b0;
            valva_lapte_q <= 1'b0;
            valva_zahar_q <= 1'b0;
            rest_q        <= 5'd0;
            rest_valid_q  <= 1'b0;
            ocupat_q      <= 1'b0;
            gata_q        <= 1'b0;
            eroare_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_cafea_q   <= sel_cafea_d;
            sel_cioco_q   <= sel_cioco_d;
            sel_lapte_q   <= sel_lapte_d;
            sel_zahar_q   <= sel_zahar_d;
            armed_q       <= armed_d;
            rest_reg_q    <= rest_reg_d;
            valva_cafea_q <= valva_cafea_d;
            valva_cioco_q <= valva_cioco_d;
            valva_lapte_q <= valva_lapte_d;
            valva_zahar_q <= valva_zahar_d;
            rest_q        <= rest_d;
            rest_valid_q  <= rest_valid_d;
            ocupat_q      <= ocupat_d;
            gata_q        <= gata_d;
            eroare_q      <= eroare_d;
        end
    end

    assign bus.valva_cafea = valva_cafea_q;
    assign bus.valva_cioco = valva_cioco_q;
    assign bus.valva_lapte = valva_lapte_q;
    assign bus.valva_zahar = valva_zahar_q;
    assign bus.rest        = rest_q;
    assign bus.rest_valid  = rest_valid_q;
    assign bus.ocupat      = ocupat_q;
    assign bus.gata        = gata_q;
    assign bus.eroare      = eroare_q;

endmodule

// File: doc/dozator.md
Name: dozator

Overview:
- Dispense sequencer on the consuming side of the coffee-machine controller's selection/message interface.
- Latches the order flags (drink, milk, sugar) and starts on the controller's Activ message (msg = 8).
- Drives timed valve outputs for base drink, milk and sugar in sequence, presents change, and signals completion.
- Sits between the menu controller and the physical valve/coin-return drivers.

Parameters:
T_BAZA, 8, base-drink valve open time in clk cycles (1..255)
T_LAPTE, 4, milk valve open time in clk cycles (1..255)
T_ZAHAR, 2, sugar valve open time in clk cycles (1..255)
PRET, 5, drink price in fund units; change = fond - PRET

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
msg  input  4  controller state code (0 Idle … 8 Activ, 9 Lapte, 10 Zahar)
cafea  input  1  coffee selected (level)
cioco  input  1  chocolate selected (level)
lapte  input  1  extra milk selected (level)
zahar  input  1  extra sugar selected (level)
fond  input  5  inserted funds, unsigned
valva_cafea  output  1  coffee valve open
valva_cioco  output  1  chocolate valve open
valva_lapte  output  1  milk valve open
valva_zahar  output  1  sugar valve open
rest  output  5  change amount; valid while rest_valid = 1
rest_valid  output  1  one-cycle change strobe
ocupat  output  1  sequence in progress
gata  output  1  one-cycle completion pulse
eroare  output  1  one-cycle pulse: start with no drink selected

Behaviour:
- Reset (rst = 1, asynchronous):
  - All outputs go to 0 immediately, including mid-dispense with valves open.
  - Order register and counter are cleared; FSM returns to ASTEPT.
- Order register (fields sel_cafea, sel_cioco, sel_lapte, sel_zahar):
  - While in ASTEPT, each bit is set on any clk edge where its input is 1; bits are sticky.
  - All bits clear on a clk edge where msg = 0 in ASTEPT.
  - Register is frozen outside ASTEPT.
- Start:
  - Start condition: in ASTEPT, msg = 8, and armed = 1.
  - armed is set when msg != 8 is sampled, and cleared on start. This gives one sequence per entry into Activ.
- Start with no drink selected (sel_cafea = 0 and sel_cioco = 0):
  - eroare = 1 for one cycle; stay in ASTEPT; armed cleared.
- Start with both drinks selected: coffee wins; chocolate is ignored.
- Funds: on start, latch rest_reg = fond - PRET.
  - Controller guarantees fond >= PRET.
  - If fond < PRET, rest_reg = 0; no wrap-around.
- FSM states: ASTEPT, BAZA, LAPTE, ZAHAR, REST, GATA.
  - ASTEPT -> BAZA on valid start; load counter with T_BAZA-1; ocupat = 1 from this edge.
  - BAZA: selected base valve = 1.
    - At count 0, go to LAPTE if sel_lapte (load T_LAPTE-1).
    - Otherwise go to ZAHAR if sel_zahar (load T_ZAHAR-1).
    - Otherwise go to REST.
  - LAPTE: valva_lapte = 1.
    - At count 0, go to ZAHAR if sel_zahar (load T_ZAHAR-1), otherwise REST.
  - ZAHAR: valva_zahar = 1; at count 0, go to REST.
  - REST: rest = rest_reg, rest_valid = 1, for exactly one cycle; then GATA.
  - GATA: gata = 1 for one cycle; ocupat = 0 from the next edge.
    - Order register clears on exit; return to ASTEPT.
- Valve outputs are registered and mutually exclusive; no cycle has two valves open.
  - Each valve is high for exactly its T_x cycles, with no gap between consecutive phases.
- Latency:
  - First valve opens 1 cycle after msg = 8 is sampled.
  - Total ocupat time = T_BAZA + (T_LAPTE if milk) + (T_ZAHAR if sugar) + 2 cycles.
- Ignored while ocupat = 1: msg changes and selection inputs.
  - msg returning to 8 during a sequence does not restart it.
  - It also does not re-arm until msg != 8 is seen.
- rest is 0 whenever rest_valid = 0.

Test Plan:
- Coffee only, fond = 7, msg: 1 -> 2 -> 5 -> 6 -> 8: valva_cafea high for 8 cycles; then rest = 2 with rest_valid for 1 cycle; then gata; ocupat high for 10 cycles.
- Chocolate + milk + sugar, fond = 5: valva_cioco 8, then valva_lapte 4, then valva_zahar 2 back-to-back; rest = 0 strobe; gata; total ocupat 16 cycles; never two valves high together.
- msg held at 8 for 40 cycles after completion: no second sequence. msg -> 6 -> 8: second sequence starts.
- Start with no selection (msg 0 -> 8 directly): eroare pulse 1 cycle; ocupat stays 0; all valves 0.
- rst asserted mid-LAPTE (between clocks): valva_lapte drops to 0 asynchronously; all outputs 0. After release, msg = 8 without new selection gives eroare only.
- cafea and cioco both asserted, fond = 3: only valva_cafea opens; rest = 0 (no wrap to 30).
